// File: rtl/branch_bht_predictor.sv
// branch_bht_predictor: 2-bit saturating-counter BHT; IF-stage prediction, EX-stage training and next-PC classification
// Optional gshare indexing with a global history register when BHT_GSHARE_EN is defined.
// Ports:
//   clk, rst_n                     rising-edge clock, asynchronous active-low reset
//   if_pc                          PC of the instruction in IF
//   if_pred_taken, if_pred_idx     combinational prediction and the table index it used
//   ex_valid, ex_is_branch,        EX-stage instruction qualifiers
//   ex_is_jump
//   ex_taken                       resolved branch outcome
//   ex_pred_taken, ex_pred_idx     prediction/index carried down from IF
//   nexttype                       00 PC+4, 01 jump, 10 branch predicted right, 11 branch mispredicted
//   bht_update                     high in any cycle where an entry is trained
module branch_bht_predictor #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] INIT_CNT = 2'b01,
    parameter int         GHR_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    output logic [IDX_W-1:0] if_pred_idx,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [IDX_W-1:0] ex_pred_idx,
    output logic [1:0]       nexttype,
    output logic             bht_update
);
    logic [1:0]       cnt [2**IDX_W];
    logic [IDX_W-1:0] idx;
    logic             upd;
    logic [1:0]       cur;
    logic             unused_pc;

    assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};
    assign upd = ex_valid & ex_is_branch & ~ex_is_jump;
    assign bht_update = upd;

`ifdef BHT_GSHARE_EN
    logic [GHR_W-1:0] ghr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr <= '0;
        else if (upd) ghr <= {ghr[GHR_W-2:0], ex_taken};
    end
    assign idx = if_pc[IDX_W+1:2] ^ IDX_W'(ghr);
`else
    assign idx = if_pc[IDX_W+1:2];
`endif

    // Lookup reads the pre-edge table: no bypass from a same-cycle update.
    assign if_pred_taken = cnt[idx][1];
    assign if_pred_idx = idx;
    assign cur = cnt[ex_pred_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++) cnt[i] <= INIT_CNT;
        end else if (upd) begin
            cnt[ex_pred_idx] <= ex_taken ? ((cur == 2'd3) ? cur : cur + 2'd1)
                                         : ((cur == 2'd0) ? cur : cur - 2'd1);
        end
    end

    // Jump outranks branch so an illegal branch+jump combination never trains.
    always_comb begin
        nexttype = !ex_valid    ? 2'b00 :
                   ex_is_jump   ? 2'b01 :
                   ex_is_branch ? ((ex_taken == ex_pred_taken) ? 2'b10 : 2'b11) :
                                  2'b00;
    end
endmodule

// File: tb/tb_branch_bht_predictor.sv
// tb_branch_bht_predictor: directed scoreboard bench for branch_bht_predictor
module tb_branch_bht_predictor;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] if_pc = 32'h0040_0000;
    logic        if_pred_taken;
    logic [5:0]  if_pred_idx;
    logic        ex_valid = 0, ex_is_branch = 0, ex_is_jump = 0, ex_taken = 0, ex_pred_taken = 0;
    logic [5:0]  ex_pred_idx = '0;
    logic [1:0]  nexttype;
    logic        bht_update;
    int          total = 0, bad = 0;

    typedef struct packed {
        logic       p;
        logic [5:0] i;
        logic [1:0] n;
        logic       u;
    } exp_t;
    exp_t q[$];

    branch_bht_predictor dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_idx(if_pred_idx),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pred_idx(ex_pred_idx),
        .nexttype(nexttype), .bht_update(bht_update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        exp_t e;
        e = q.pop_front();
        total += 4;
        assert (if_pred_taken === e.p) else begin bad++; $error("FAIL %s pred obs=%0b exp=%0b", tag, if_pred_taken, e.p); end
        assert (if_pred_idx === e.i) else begin bad++; $error("FAIL %s idx obs=%0d exp=%0d", tag, if_pred_idx, e.i); end
        assert (nexttype === e.n) else begin bad++; $error("FAIL %s nexttype obs=%b exp=%b", tag, nexttype, e.n); end
        assert (bht_update === e.u) else begin bad++; $error("FAIL %s upd obs=%0b exp=%0b", tag, bht_update, e.u); end
    endtask

    // Drive one EX/IF cycle after the falling edge, queue the expectation, compare before the rising edge.
    task automatic step(input string tag, input logic [31:0] pc, input logic v, input logic b, input logic j,
                        input logic t, input logic pt, input logic [5:0] pi,
                        input logic ep, input logic [5:0] ei, input logic [1:0] en, input logic eu);
        @(negedge clk);
        if_pc = pc; ex_valid = v; ex_is_branch = b; ex_is_jump = j;
        ex_taken = t; ex_pred_taken = pt; ex_pred_idx = pi;
        q.push_back('{ep, ei, en, eu});
        #1 check(tag);
    endtask

    initial begin
        #2;
        q.push_back('{1'b0, 6'd0, 2'b00, 1'b0});
        check("reset");
        @(negedge clk) rst_n = 1;
`ifdef BHT_GSHARE_EN
        step("gs0", 32'h0, 1, 1, 0, 1, 0, 6'd0, 0, 6'd0, 2'b11, 1);
        step("gs1", 32'h0, 1, 1, 0, 1, 0, 6'd0, 0, 6'd1, 2'b11, 1);
        step("gs2", 32'h0, 0, 0, 0, 0, 0, 6'd0, 0, 6'd3, 2'b00, 0);
`else
        step("inc1", 32'h14, 1, 1, 0, 1, 0, 6'd5, 0, 6'd5, 2'b11, 1);
        step("inc2", 32'h14, 1, 1, 0, 1, 0, 6'd5, 1, 6'd5, 2'b11, 1);
        step("inc3", 32'h14, 1, 1, 0, 1, 0, 6'd5, 1, 6'd5, 2'b11, 1);
        step("idle5", 32'h14, 0, 0, 0, 0, 0, 6'd0, 1, 6'd5, 2'b00, 0);
        step("dec1", 32'h14, 1, 1, 0, 0, 1, 6'd5, 1, 6'd5, 2'b11, 1);
        step("dec2", 32'h14, 1, 1, 0, 0, 1, 6'd5, 1, 6'd5, 2'b11, 1);
        step("dec3", 32'h14, 1, 1, 0, 0, 0, 6'd5, 0, 6'd5, 2'b10, 1);
        step("dec4", 32'h14, 1, 1, 0, 0, 0, 6'd5, 0, 6'd5, 2'b10, 1);
        step("sat0", 32'h14, 1, 1, 0, 1, 0, 6'd5, 0, 6'd5, 2'b11, 1);
        step("at1", 32'h14, 0, 0, 0, 0, 0, 6'd0, 0, 6'd5, 2'b00, 0);
        step("jump", 32'h14, 1, 1, 1, 1, 0, 6'd5, 0, 6'd5, 2'b01, 0);
        step("nojtr", 32'h14, 0, 0, 0, 0, 0, 6'd0, 0, 6'd5, 2'b00, 0);
        step("same9", 32'h24, 1, 1, 0, 1, 0, 6'd9, 0, 6'd9, 2'b11, 1);
        step("new9", 32'h24, 1, 1, 0, 1, 1, 6'd9, 1, 6'd9, 2'b10, 1);
        step("bubble", 32'h24, 0, 1, 0, 0, 1, 6'd9, 1, 6'd9, 2'b00, 0);
        step("dec9a", 32'h24, 1, 1, 0, 0, 1, 6'd9, 1, 6'd9, 2'b11, 1);
        step("dec9b", 32'h24, 1, 1, 0, 0, 0, 6'd9, 1, 6'd9, 2'b10, 1);
        step("nonbr", 32'h24, 1, 0, 0, 1, 0, 6'd9, 0, 6'd9, 2'b00, 0);
        step("pre_rst", 32'h14, 1, 1, 0, 1, 0, 6'd5, 0, 6'd5, 2'b11, 1);
        step("trained", 32'h14, 0, 0, 0, 0, 0, 6'd0, 1, 6'd5, 2'b00, 0);
        rst_n = 0;
        q.push_back('{1'b0, 6'd5, 2'b00, 1'b0});
        #1 check("midrst");
        @(negedge clk) rst_n = 1;
        step("postrst", 32'h14, 0, 0, 0, 0, 0, 6'd0, 0, 6'd5, 2'b00, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_bht_predictor.md
Name: branch_bht_predictor

Overview:
- Branch history table (BHT) of 2-bit saturating counters for the 5-stage pipeline.
- IF stage: gives a taken/not-taken prediction for the fetched PC.
- EX stage: compares the resolved outcome with the prediction carried down the pipe, trains the table, and classifies the next-PC action as `nexttype` (PC+4 / Jump / Branch-correct / Branch-wrong) for the hazard/stall controller.

Parameters:
- IDX_W, 6, table index width; table has 2^IDX_W entries.
- INIT_CNT, 2'b01, counter value loaded into every entry on reset (weakly not-taken).
- GHR_W, 6, global history length; used only with GSHARE_EN; must be <= IDX_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  PC of the instruction in IF
- if_pred_taken  out  1  prediction for if_pc; combinational
- if_pred_idx  out  IDX_W  table index used for this prediction; carried down the pipe
- ex_valid  in  1  EX holds a real instruction (0 for a bubble or flush)
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_is_jump  in  1  EX instruction is j/jal/jr
- ex_taken  in  1  resolved branch outcome
- ex_pred_taken  in  1  prediction made in IF, pipelined with the instruction
- ex_pred_idx  in  IDX_W  index made in IF, pipelined with the instruction
- nexttype  out  2  00 PCPlus4, 01 Jump, 10 Branch (predicted right), 11 BranchWrong; combinational
- bht_update  out  1  pulses high in any cycle where an entry is trained

Behaviour:
- Storage:
  - cnt[0..2^IDX_W-1], 2 bits each.
  - Async reset sets every entry to INIT_CNT.
  - No other outputs are registered; all combinational outputs settle from reset state (if_pred_taken = INIT_CNT[1]).
- Index without GSHARE_EN: idx = if_pc[IDX_W+1:2]. Bits [1:0] are ignored.
- Prediction: if_pred_taken = cnt[idx][1]; if_pred_idx = idx.
- Update condition: upd = ex_valid & ex_is_branch & ~ex_is_jump. bht_update = upd.
- On clk rising with upd, counter at ex_pred_idx saturates:
  - ex_taken = 1: 0→1→2→3, stays at 3.
  - ex_taken = 0: 3→2→1→0, stays at 0.
  - Single-cycle latency: a new value is visible to a lookup in the cycle after the edge.
- Same-cycle lookup and update of the same index: prediction returns the pre-update value. No bypass.
- nexttype, priority order:
  1. ~ex_valid → 00.
  2. ex_is_jump → 01. Jump wins if ex_is_branch is also set (illegal combination); no training.
  3. ex_is_branch & (ex_taken == ex_pred_taken) → 10.
  4. ex_is_branch & mismatch → 11.
  5. Otherwise → 00.
- Stalls: the hazard controller bubbles EX (ex_valid = 0) during a load stall, so each branch trains exactly once. The block has no stall input.
- Reset asserted mid-operation: the table is cleared immediately; an update pending that edge is lost.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- Defined:
  - Adds a GHR_W-bit global history register ghr, async reset to 0.
  - idx = if_pc[IDX_W+1:2] XOR {zeros, ghr}.
  - On every upd edge: ghr <= {ghr[GHR_W-2:0], ex_taken}.
  - Training still uses ex_pred_idx, so no recomputation is needed.
- Undefined: no ghr flops; the plain PC index is used; port list is identical.

Test Plan:
- Reset, if_pc = 0x0040_0000 → if_pred_taken = 0; if_pred_idx = 0; nexttype = 00; bht_update = 0.
- Idx 5 (if_pc = 0x14): three trainings with ex_taken = 1, ex_pred_taken = 0 → nexttype = 11 on each; entry goes 1→2→3→3; if_pred_taken = 1 after the first edge.
- Idx 5 from 3: ex_taken = 0 four times → 3→2→1→0→0; prediction flips to 0 after the second edge; nexttype = 10 only when ex_pred_taken matches.
- ex_valid = 1, ex_is_jump = 1, ex_is_branch = 1 → nexttype = 01; bht_update = 0; table unchanged.
- Same-cycle update and lookup on idx 9 → lookup shows the old value; the following cycle shows the new value. ex_valid = 0 with ex_is_branch = 1 → no update; nexttype = 00.
- BHT_GSHARE_EN: train taken twice at idx 0 → ghr = 0b000011; lookup if_pc = 0x0 gives if_pred_idx = 3.
